// File: rtl/rx_sync_controller.sv
// rx_sync_controller: receive-side lock sequencer for the optical audio link.
// It tracks the A/B subframe sequence coming out of frame_dismantle, pulses a
// datapath reset on loss of sync, and pairs A/B subframes into stereo samples
// that are handed to the sample FIFO through a one-entry valid/ready buffer.
module rx_sync_controller #(
    parameter int SAMPLE_W    = 20,
    parameter int LOCK_FRAMES = 8,
    parameter int TIMEOUT     = 4096,
    parameter int RST_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sf_valid,
    input  logic [SAMPLE_W-1:0] sf_data,
    input  logic                sf_channel,
    input  logic [7:0]          sf_frame,
    input  logic                dp_kill,
    output logic                dp_rst,
    output logic                locked,
    output logic                pair_valid,
    input  logic                pair_ready,
    output logic [SAMPLE_W-1:0] pair_left,
    output logic [SAMPLE_W-1:0] pair_right,
    output logic                pair_block_start,
    output logic [7:0]          overflow_count,
    output logic [7:0]          resync_count
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int GF_W = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {RESET_DP, SEARCH, ACQUIRE, LOCKED} state_t;

    state_t              state, state_next;
    logic [RC_W-1:0]     rst_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [GF_W-1:0]     good_cnt;
    logic                exp_b;        // next subframe must be channel B
    logic [7:0]          exp_frame;    // frame number expected on the next subframe
    logic [SAMPLE_W-1:0] left_hold;

    logic tracking, seq_ok, seq_err, timeout_err, err;
    logic good_a, good_b, pair_done, lock_hit, search_hit, rst_done;

    // Qualify the incoming subframe against the expected sequence.
    assign tracking    = (state == ACQUIRE) || (state == LOCKED);
    assign seq_ok      = (sf_channel == exp_b) && (sf_frame == exp_frame);
    assign seq_err     = tracking && sf_valid && !seq_ok;
    assign timeout_err = tracking && (to_cnt == TO_W'(TIMEOUT));
    // A kill and a sequence error in the same cycle collapse into one error.
    assign err         = tracking && (dp_kill || seq_err || timeout_err);
    assign good_a      = tracking && sf_valid && seq_ok && !exp_b && !err;
    assign good_b      = tracking && sf_valid && seq_ok &&  exp_b && !err;
    assign pair_done   = (state == LOCKED) && good_b;
    assign lock_hit    = (state == ACQUIRE) && good_b && (good_cnt == GF_W'(LOCK_FRAMES - 1));
    assign search_hit  = (state == SEARCH) && sf_valid && !sf_channel && (sf_frame == 8'd0);
    assign rst_done    = (rst_cnt == RC_W'(RST_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge values regardless of block ordering.
        if (!rst) state <= RESET_DP;
        else      state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            RESET_DP: if (rst_done)   state_next = SEARCH;
            SEARCH:   if (search_hit) state_next = ACQUIRE;
            ACQUIRE:  if (err)        state_next = RESET_DP;
                      else if (lock_hit) state_next = LOCKED;
            LOCKED:   if (err)        state_next = RESET_DP;
            default:                  state_next = RESET_DP;
        endcase
    end

    // Datapath: counters, sequence tracking, pair assembly, output buffer, stats.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dp_rst           <= 1'b1;
            locked           <= 1'b0;
            rst_cnt          <= '0;
            to_cnt           <= '0;
            good_cnt         <= '0;
            exp_b            <= 1'b0;
            exp_frame        <= 8'd0;
            left_hold        <= '0;
            pair_valid       <= 1'b0;
            pair_left        <= '0;
            pair_right       <= '0;
            pair_block_start <= 1'b0;
            overflow_count   <= 8'd0;
            resync_count     <= 8'd0;
        end else begin
            dp_rst  <= (state_next == RESET_DP);
            locked  <= (state_next == LOCKED);
            rst_cnt <= (state == RESET_DP && state_next == RESET_DP) ? rst_cnt + 1'b1 : '0;

            if (!tracking || sf_valid || err) to_cnt <= '0;
            else                              to_cnt <= to_cnt + 1'b1;

            if (search_hit) begin
                exp_b     <= 1'b1;
                exp_frame <= 8'd0;
            end else if (good_a) begin
                exp_b <= 1'b1;
            end else if (good_b) begin
                exp_b     <= 1'b0;
                exp_frame <= (exp_frame == 8'd191) ? 8'd0 : exp_frame + 8'd1;
            end

            if (err || state != ACQUIRE) good_cnt <= '0;
            else if (good_b)             good_cnt <= good_cnt + 1'b1;

            if (err)                              left_hold <= '0;
            else if (state == LOCKED && good_a)   left_hold <= sf_data;

            if (err) begin
                pair_valid       <= 1'b0;
                pair_left        <= '0;
                pair_right       <= '0;
                pair_block_start <= 1'b0;
            end else if (pair_done && (!pair_valid || pair_ready)) begin
                pair_valid       <= 1'b1;
                pair_left        <= left_hold;
                pair_right       <= sf_data;
                pair_block_start <= (sf_frame == 8'd0);
            end else if (pair_valid && pair_ready) begin
                pair_valid <= 1'b0;
            end

            if (pair_done && pair_valid && !pair_ready && overflow_count != 8'hFF)
                overflow_count <= overflow_count + 8'd1;

            if (err && state == LOCKED && resync_count != 8'hFF)
                resync_count <= resync_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_rx_sync_controller.sv
// Self-checking bench for rx_sync_controller: scoreboard of expected pairs,
// a table of locked-phase vectors across the block wrap, and hand-written
// sequences for sequence error, backpressure, timeout, kill and reset.
module tb_rx_sync_controller;

    localparam int SW = 20;

    typedef struct {
        logic [SW-1:0] left;
        logic [SW-1:0] right;
        logic          bs;
    } pair_t;

    typedef struct {
        int            frame;
        logic [SW-1:0] left;
        logic [SW-1:0] right;
        logic          exp_bs;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sf_valid = 1'b0;
    logic [SW-1:0] sf_data = '0;
    logic          sf_channel = 1'b0;
    logic [7:0]    sf_frame = 8'd0;
    logic          dp_kill = 1'b0;
    logic          pair_ready = 1'b1;
    logic          dp_rst, locked, pair_valid, pair_block_start;
    logic [SW-1:0] pair_left, pair_right;
    logic [7:0]    overflow_count, resync_count;

    int checks = 0;
    int errors = 0;
    int pairs_seen = 0;
    pair_t exp_q[$];
    vec_t  vecs[12];

    rx_sync_controller dut (
        .clk(clk), .rst(rst), .sf_valid(sf_valid), .sf_data(sf_data),
        .sf_channel(sf_channel), .sf_frame(sf_frame), .dp_kill(dp_kill),
        .dp_rst(dp_rst), .locked(locked), .pair_valid(pair_valid),
        .pair_ready(pair_ready), .pair_left(pair_left), .pair_right(pair_right),
        .pair_block_start(pair_block_start), .overflow_count(overflow_count),
        .resync_count(resync_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sf(input logic ch, input int f, input logic [SW-1:0] d);
        sf_valid   = 1'b1;
        sf_channel = ch;
        sf_frame   = 8'(f);
        sf_data    = d;
        step(1);
        sf_valid   = 1'b0;
    endtask

    task automatic send_frame(input int f, input logic [SW-1:0] l, input logic [SW-1:0] r,
                              input bit expect_pair);
        pair_t p;
        send_sf(1'b0, f, l);
        if (expect_pair) begin
            p.left = l; p.right = r; p.bs = (f == 0);
            exp_q.push_back(p);
        end
        send_sf(1'b1, f, r);
    endtask

    // Count cycles with dp_rst high, starting from the current cycle.
    task automatic count_dp_rst(input string name);
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dp_rst) n++;
            else break;
        end
        check(name, n, 4);
        step(1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dp_rst"}, dp_rst, 1);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_pair_valid"}, pair_valid, 0);
        check({tag, "_pair_left"}, pair_left, 0);
        check({tag, "_pair_right"}, pair_right, 0);
        check({tag, "_block_start"}, pair_block_start, 0);
        check({tag, "_overflow"}, overflow_count, 0);
        check({tag, "_resync"}, resync_count, 0);
    endtask

    // Scoreboard: compare every transferred pair against the queue head.
    always @(negedge clk) begin
        if (rst && pair_valid && pair_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pair actual=%0h/%0h required=none", pair_left, pair_right);
            end else begin
                pair_t e;
                e = exp_q.pop_front();
                check("pair_left", pair_left, e.left);
                check("pair_right", pair_right, e.right);
                check("pair_block_start", pair_block_start, e.bs);
                pairs_seen++;
            end
        end
    end

    initial begin
        int n;
        vecs[0]  = '{0,  20'h00000, 20'hFFFFF, 1'b1};
        vecs[1]  = '{1,  20'hAAAAA, 20'h55555, 1'b0};
        vecs[2]  = '{2,  20'h55555, 20'hAAAAA, 1'b0};
        vecs[3]  = '{3,  20'h00001, 20'h80000, 1'b0};
        vecs[4]  = '{4,  20'h80000, 20'h00001, 1'b0};
        vecs[5]  = '{5,  20'h12345, 20'h6789A, 1'b0};
        vecs[6]  = '{6,  20'hFFFFF, 20'h00000, 1'b0};
        vecs[7]  = '{7,  20'h0F0F0, 20'hF0F0F, 1'b0};
        vecs[8]  = '{8,  20'h00000, 20'h00000, 1'b0};
        vecs[9]  = '{9,  20'hFFFFE, 20'h7FFFF, 1'b0};
        vecs[10] = '{10, 20'hC3C3C, 20'h3C3C3, 1'b0};
        vecs[11] = '{11, 20'hDEAD0, 20'hBEEF0, 1'b0};

        // Reset state and dp_rst pulse length after release.
        step(1);
        check_reset_values("reset");
        step(1);
        rst = 1'b1;
        count_dp_rst("dp_rst_after_release");

        // Clean block: lock after frame 7 B, then 184 all-ones pairs.
        for (int f = 0; f < 192; f++) begin
            send_frame(f, 20'hFFFFF, 20'hFFFFF, f >= 8);
            if (f == 6) check("locked_before_lock", locked, 0);
            if (f == 7) check("locked_after_frame7", locked, 1);
            if (f == 8) check("pair_valid_latency", pair_valid, 1);
        end
        step(2);
        check("clean_block_pairs", pairs_seen, 184);

        // Block wrap via table: frame 0 pair carries block_start.
        foreach (vecs[i]) send_frame(vecs[i].frame, vecs[i].left, vecs[i].right, 1'b1);
        step(2);
        check("wrap_locked", locked, 1);
        check("wrap_resync", resync_count, 0);
        check("wrap_overflow", overflow_count, 0);

        // Sequence error: A, B, B on frame 12.
        send_frame(12, 20'h11111, 20'h22222, 1'b1);
        send_sf(1'b1, 12, 20'h33333);
        check("seqerr_locked", locked, 0);
        check("seqerr_resync", resync_count, 1);
        check("seqerr_pair_cleared", pair_valid, 0);
        count_dp_rst("seqerr_dp_rst");
        for (int f = 13; f < 21; f++) send_frame(f, 20'h1, 20'h2, 1'b0);
        check("search_ignores_nonzero", locked, 0);
        for (int f = 0; f < 8; f++) begin
            send_frame(f, 20'h3, 20'h4, 1'b0);
            if (f == 6) check("relock_not_yet", locked, 0);
        end
        check("relock", locked, 1);

        // Backpressure: three completions with ready low.
        pair_ready = 1'b0;
        send_frame(8, 20'hA0001, 20'hB0001, 1'b1);
        send_frame(9, 20'hA0002, 20'hB0002, 1'b0);
        send_frame(10, 20'hA0003, 20'hB0003, 1'b0);
        check("bp_held_left", pair_left, 20'hA0001);
        check("bp_held_right", pair_right, 20'hB0001);
        check("bp_valid", pair_valid, 1);
        check("bp_overflow", overflow_count, 2);
        pair_ready = 1'b1;
        step(1);
        check("bp_released", pair_valid, 0);

        // Ready high in the same cycle as a completion: load, no overflow.
        pair_ready = 1'b0;
        send_frame(11, 20'hA0011, 20'hB0011, 1'b1);
        send_sf(1'b0, 12, 20'hA0012);
        pair_ready = 1'b1;
        begin
            pair_t p;
            p.left = 20'hA0012; p.right = 20'hB0012; p.bs = 1'b0;
            exp_q.push_back(p);
        end
        send_sf(1'b1, 12, 20'hB0012);
        check("same_cycle_load_valid", pair_valid, 1);
        check("same_cycle_overflow", overflow_count, 2);
        step(2);

        // Timeout: locked falls TIMEOUT+1 cycles after the last subframe cycle.
        send_frame(13, 20'h5, 20'h6, 1'b1);
        n = 0;
        while (locked && n < 5000) begin
            step(1);
            n++;
        end
        check("timeout_cycles", n, 4097);
        check("timeout_resync", resync_count, 2);
        step(6);
        for (int f = 0; f < 8; f++) send_frame(f, 20'h7, 20'h8, 1'b0);
        check("relock_after_timeout", locked, 1);

        // One-cycle kill.
        dp_kill = 1'b1;
        step(1);
        dp_kill = 1'b0;
        check("kill_locked", locked, 0);
        check("kill_dp_rst", dp_rst, 1);
        check("kill_resync", resync_count, 3);
        step(6);
        for (int f = 0; f < 8; f++) send_frame(f, 20'h9, 20'hA, 1'b0);
        check("relock_after_kill", locked, 1);

        // Reset while a pair is held mid-handshake.
        pair_ready = 1'b0;
        send_frame(8, 20'hCAFE0, 20'hBEEF1, 1'b0);
        check("mid_hs_valid", pair_valid, 1);
        rst = 1'b0;
        step(1);
        check_reset_values("mid_hs_reset");
        rst = 1'b1;
        pair_ready = 1'b1;
        step(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the run wanders off.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
